spi_frame_buffer: RTL

SPI_FRAME_BUFFER -- requirements
Module: spi_frame_buffer

---
 rtl/spi_frame_pkg.sv | 13 +
 rtl/spi_frame_buffer_sync_edge.sv | 33 +++
 rtl/spi_frame_buffer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/spi_frame_pkg.sv
// Shared constants and state encoding for the SPI command/status frame buffer.
package spi_frame_pkg;

  localparam int FRAME_BYTES_DEF = 89;
  localparam int TX_BYTES_DEF    = 48;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/spi_frame_buffer_sync_edge.sv
// Multi-stage synchronizer with change detection; the caller decodes edge
// polarity from the synchronized level.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic change
);

  logic [STAGES-1:0] pipe;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe <= {STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        pipe[i] <= pipe[i-1];
      end
      prev <= pipe[STAGES-1];
    end
  end

  assign level  = pipe[STAGES-1];
  assign change = level ^ prev;

endmodule

// File: rtl/spi_frame_buffer.sv
// Receives fixed-length SPI command frames into ping-pong banks and feeds
// status bytes back to the SPI slave one byte ahead of the shifter.
module spi_frame_buffer
  import spi_frame_pkg::*;
#(
  parameter int FRAME_BYTES = FRAME_BYTES_DEF,
  parameter int TX_BYTES    = TX_BYTES_DEF
) (
  input  logic       iCLK,
  input  logic       iRESETn,
  input  logic       iFRAME_n,
  input  logic       iRX_VALID,
  input  logic [7:0] iRX_DATA,
  output logic [7:0] oTX_DATA,
  output logic       oTX_WREN,
  output logic       oFRAME_DONE,
  output logic       oFRAME_ERR,
  output logic       oBUSY,
  input  logic [6:0] iRD_ADDR,
  output logic [7:0] oRD_DATA,
  input  logic       iTX_WE,
  input  logic [5:0] iTX_ADDR,
  input  logic [7:0] iTX_DATA
);

  localparam int             RXW       = $clog2(FRAME_BYTES);
  localparam int             TXW       = $clog2(TX_BYTES);
  localparam logic [7:0]     FRAME_LEN = 8'(FRAME_BYTES);
  localparam logic [8:0]     TX_LEN    = 9'(TX_BYTES);
  localparam logic [TXW-1:0] TX_FIRST  = '0;

  logic [7:0] rx_mem [2][FRAME_BYTES];
  logic [7:0] tx_mem [TX_BYTES];

  state_t     state, state_next;
  logic [7:0] count, count_next;
  logic       overrun, overrun_next;
  logic       rd_bank, rd_bank_next;
  logic       wr_bank, wr_bank_next;
  logic [7:0] tx_data_next;
  logic       tx_wren_next, done_next, err_next;
  logic       rx_we;
  logic [8:0] tx_idx;
  logic [1:0] warm;
  logic       armed;

  logic frame_level, frame_change, frame_fall;
  logic rx_level, rx_change, byte_event;

  sync_edge #(.STAGES(2), .RESET_VAL(1'b1)) u_frame_sync (
    .clk    (iCLK),
    .rst_n  (iRESETn),
    .din    (iFRAME_n),
    .level  (frame_level),
    .change (frame_change)
  );

  sync_edge #(.STAGES(1), .RESET_VAL(1'b0)) u_valid_sync (
    .clk    (iCLK),
    .rst_n  (iRESETn),
    .din    (iRX_VALID),
    .level  (rx_level),
    .change (rx_change)
  );

  assign frame_fall = frame_change & ~frame_level;
  assign byte_event = rx_change & rx_level;
  assign oBUSY      = (state != IDLE);

  always_comb begin
    state_next   = state;
    count_next   = count;
    overrun_next = overrun;
    rd_bank_next = rd_bank;
    wr_bank_next = wr_bank;
    tx_data_next = oTX_DATA;
    tx_wren_next = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;
    rx_we        = 1'b0;
    tx_idx       = {1'b0, count} + 9'd1;
    case (state)
      IDLE: begin
        if (frame_fall && armed) begin
          count_next   = 8'd0;
          tx_data_next = tx_mem[TX_FIRST];
          tx_wren_next = 1'b1;
          state_next   = RECEIVE;
        end
      end
      RECEIVE: begin
        if (byte_event) begin
          if (count < FRAME_LEN) begin
            rx_we        = 1'b1;
            tx_data_next = (tx_idx < TX_LEN) ? tx_mem[tx_idx[TXW-1:0]] : 8'h00;
          end else begin
            overrun_next = 1'b1;
            tx_data_next = 8'h00;
          end
          tx_wren_next = 1'b1;
          if (count != 8'hFF) begin
            count_next = count + 8'd1;
          end
        end
        if (frame_level) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        if (count == FRAME_LEN && !overrun) begin
          rd_bank_next = wr_bank;
          wr_bank_next = ~wr_bank;
          done_next    = 1'b1;
        end else begin
          err_next = 1'b1;
        end
        overrun_next = 1'b0;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame starts are only honoured once the pin has been seen idle after reset,
  // so a reset in the middle of a frame cannot fake a falling edge.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      state       <= IDLE;
      count       <= 8'd0;
      overrun     <= 1'b0;
      rd_bank     <= 1'b1;
      wr_bank     <= 1'b0;
      oTX_DATA    <= 8'h00;
      oTX_WREN    <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oFRAME_ERR  <= 1'b0;
      oRD_DATA    <= 8'h00;
      warm        <= 2'b00;
      armed       <= 1'b0;
    end else begin
      state       <= state_next;
      count       <= count_next;
      overrun     <= overrun_next;
      rd_bank     <= rd_bank_next;
      wr_bank     <= wr_bank_next;
      oTX_DATA    <= tx_data_next;
      oTX_WREN    <= tx_wren_next;
      oFRAME_DONE <= done_next;
      oFRAME_ERR  <= err_next;
      oRD_DATA    <= ({1'b0, iRD_ADDR} < FRAME_LEN) ? rx_mem[rd_bank][iRD_ADDR[RXW-1:0]] : 8'h00;
      warm        <= {warm[0], 1'b1};
      armed       <= armed | (warm[1] & frame_level);
    end
  end

  always_ff @(posedge iCLK) begin
    if (rx_we) begin
      rx_mem[wr_bank][count[RXW-1:0]] <= iRX_DATA;
    end
    if (iTX_WE && ({3'b000, iTX_ADDR} < TX_LEN)) begin
      tx_mem[iTX_ADDR[TXW-1:0]] <= iTX_DATA;
    end
  end

endmodule
